point_controller_v2: RTL and testbench

//  Parametrised next-gen pointwise (1x1) convolution sequencer for the MobileNetV3 accelerator.

---
 rtl/point_controller_v2.sv | 273 +++++++++++++++++++++++++++
 tb/tb_point_controller_v2.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/point_controller_v2.sv
`default_nettype none
// ============================================================================
//  Module      : point_controller_v2
//  Description : Pointwise (1x1) convolution sequencer. Walks the filter x
//                pixel x channel loops (channel innermost), issues weight and
//                feature-map read strobes/addresses, and emits one delayed
//                write strobe per output pixel through a PIPE_LAT-deep delay
//                line that mirrors the MAC + activation path depth.
//  Revision    : 1.0 - initial release
// ============================================================================
module point_controller_v2 #(
    parameter int W_ADDR_W  = 10,
    parameter int RD_ADDR_W = 13,
    parameter int WR_ADDR_W = 14,
    parameter int WIN_W     = 14,
    parameter int CH_W      = 4,
    parameter int FN_W      = 6,
    parameter int PIPE_LAT  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Point_Enable,
    input  logic [W_ADDR_W-1:0]  W_start_address,
    input  logic [RD_ADDR_W-1:0] rd_base_address,
    input  logic [WR_ADDR_W-1:0] wr_base_address,
    input  logic [CH_W-1:0]      filter_channel_max,
    input  logic [FN_W-1:0]      filter_number_max,
    input  logic [WIN_W-1:0]     window_size_max,
    input  logic                 activation_function_enable,
    input  logic                 stall,
    output logic                 weights_read_en,
    output logic [W_ADDR_W-1:0]  weights_address,
    output logic                 data_read_en,
    output logic [RD_ADDR_W-1:0] read_data_address,
    output logic                 data_write_en,
    output logic [WR_ADDR_W-1:0] write_data_address,
    output logic                 act_en,
    output logic                 acc_clear,
    output logic                 busy,
    output logic                 Point_End
);

    localparam int c_DL_LAST = PIPE_LAT - 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Sequencer state and loop counters
    state_t               state_q, state_d;
    logic [FN_W-1:0]      f_q, f_d;
    logic [WIN_W-1:0]     p_q, p_d;
    logic [CH_W-1:0]      c_q, c_d;

    // Configuration captured at start
    logic [W_ADDR_W-1:0]  w_base_q, w_base_d;
    logic [RD_ADDR_W-1:0] rd_base_q, rd_base_d;
    logic [WR_ADDR_W-1:0] wr_base_q, wr_base_d;
    logic [CH_W-1:0]      ch_max_q, ch_max_d;
    logic [FN_W-1:0]      fn_max_q, fn_max_d;
    logic [WIN_W-1:0]     win_max_q, win_max_d;
    logic                 act_q, act_d;

    // Write-strobe delay line (stage 0 = newest)
    logic                 dl_valid_q [PIPE_LAT];
    logic                 dl_valid_d [PIPE_LAT];
    logic [WR_ADDR_W-1:0] dl_addr_q  [PIPE_LAT];
    logic [WR_ADDR_W-1:0] dl_addr_d  [PIPE_LAT];

    // Last issued addresses, shown on the address ports between strobes
    logic [W_ADDR_W-1:0]  w_addr_q, w_addr_d;
    logic [RD_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [WR_ADDR_W-1:0] wr_addr_q, wr_addr_d;

    logic                 busy_q, busy_d;
    logic                 point_end_q, point_end_d;

    // Combinational helpers
    logic                 w_run_fire;
    logic                 w_c_last;
    logic                 w_p_last;
    logic                 w_f_last;
    logic                 w_cfg_empty;
    logic                 w_dl_shift;
    logic                 w_dl_pending;
    logic                 w_wr_fire;
    logic [W_ADDR_W-1:0]  w_w_addr;
    logic [RD_ADDR_W-1:0] w_rd_addr;
    logic [WR_ADDR_W-1:0] w_wr_addr;

    // Loop-position flags and full-width address arithmetic, truncated to port width
    always_comb begin
        w_run_fire  = (state_q == ST_RUN) && !stall;
        w_c_last    = (c_q == ch_max_q - CH_W'(1));
        w_p_last    = (p_q == win_max_q - WIN_W'(1));
        w_f_last    = (f_q == fn_max_q - FN_W'(1));
        w_cfg_empty = (ch_max_q == '0) || (fn_max_q == '0) || (win_max_q == '0);
        w_dl_shift  = !stall && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
        w_wr_fire   = w_dl_shift && dl_valid_q[c_DL_LAST];
        w_rd_addr   = RD_ADDR_W'(32'(rd_base_q) + 32'(c_q) * 32'(win_max_q) + 32'(p_q));
        w_w_addr    = W_ADDR_W'(32'(w_base_q) + 32'(f_q) * 32'(ch_max_q) + 32'(c_q));
        w_wr_addr   = WR_ADDR_W'(32'(wr_base_q) + 32'(f_q) * 32'(win_max_q) + 32'(p_q));
    end

    // Any write still in flight that will not leave on this edge
    always_comb begin
        w_dl_pending = 1'b0;
        for (int i = 0; i < PIPE_LAT - 1; i++) begin
            w_dl_pending = w_dl_pending | dl_valid_q[i];
        end
    end

    // Next-state logic: FSM, loop counters, config capture, delay line, address hold
    always_comb begin
        state_d    = state_q;
        f_d        = f_q;
        p_d        = p_q;
        c_d        = c_q;
        w_base_d   = w_base_q;
        rd_base_d  = rd_base_q;
        wr_base_d  = wr_base_q;
        ch_max_d   = ch_max_q;
        fn_max_d   = fn_max_q;
        win_max_d  = win_max_q;
        act_d      = act_q;
        dl_valid_d = dl_valid_q;
        dl_addr_d  = dl_addr_q;
        w_addr_d   = w_addr_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (Point_Enable) begin
                    w_base_d  = W_start_address;
                    rd_base_d = rd_base_address;
                    wr_base_d = wr_base_address;
                    ch_max_d  = filter_channel_max;
                    fn_max_d  = filter_number_max;
                    win_max_d = window_size_max;
                    act_d     = activation_function_enable;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                f_d = '0;
                p_d = '0;
                c_d = '0;
                if (!stall) begin
                    state_d = w_cfg_empty ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (!w_c_last) begin
                        c_d = c_q + CH_W'(1);
                    end else begin
                        c_d = '0;
                        if (!w_p_last) begin
                            p_d = p_q + WIN_W'(1);
                        end else begin
                            p_d = '0;
                            if (w_f_last) begin
                                state_d = ST_DRAIN;
                            end else begin
                                f_d = f_q + FN_W'(1);
                            end
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (!stall && !w_dl_pending) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The last-channel read of each pixel launches that pixel's write
        if (w_dl_shift) begin
            dl_valid_d[0] = w_run_fire && w_c_last;
            dl_addr_d[0]  = w_wr_addr;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_valid_d[i] = dl_valid_q[i-1];
                dl_addr_d[i]  = dl_addr_q[i-1];
            end
        end

        if (w_run_fire) begin
            w_addr_d  = w_w_addr;
            rd_addr_d = w_rd_addr;
        end
        if (w_wr_fire) begin
            wr_addr_d = dl_addr_q[c_DL_LAST];
        end
    end

    // Status flags follow the state being entered so they are registered with it
    always_comb begin
        busy_d      = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
        point_end_d = (state_d == ST_DONE);
    end

    // Single state register; reset returns to IDLE and flushes in-flight writes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            f_q         <= '0;
            p_q         <= '0;
            c_q         <= '0;
            w_base_q    <= '0;
            rd_base_q   <= '0;
            wr_base_q   <= '0;
            ch_max_q    <= '0;
            fn_max_q    <= '0;
            win_max_q   <= '0;
            act_q       <= 1'b0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_valid_q[i] <= 1'b0;
                dl_addr_q[i]  <= '0;
            end
            w_addr_q    <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            busy_q      <= 1'b0;
            point_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            f_q         <= f_d;
            p_q         <= p_d;
            c_q         <= c_d;
            w_base_q    <= w_base_d;
            rd_base_q   <= rd_base_d;
            wr_base_q   <= wr_base_d;
            ch_max_q    <= ch_max_d;
            fn_max_q    <= fn_max_d;
            win_max_q   <= win_max_d;
            act_q       <= act_d;
            dl_valid_q  <= dl_valid_d;
            dl_addr_q   <= dl_addr_d;
            w_addr_q    <= w_addr_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            busy_q      <= busy_d;
            point_end_q <= point_end_d;
        end
    end

    // Strobes qualify on the live stall so a stalled cycle never shows a strobe;
    // address ports show the current issue or else hold the last one issued.
    assign weights_read_en    = w_run_fire;
    assign data_read_en       = w_run_fire;
    assign acc_clear          = w_run_fire && (c_q == '0);
    assign weights_address    = w_run_fire ? w_w_addr : w_addr_q;
    assign read_data_address  = w_run_fire ? w_rd_addr : rd_addr_q;
    assign data_write_en      = w_wr_fire;
    assign write_data_address = w_wr_fire ? dl_addr_q[c_DL_LAST] : wr_addr_q;
    assign act_en             = w_wr_fire && act_q;
    assign busy               = busy_q;
    assign Point_End          = point_end_q;

endmodule
`default_nettype wire

// File: tb/tb_point_controller_v2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_point_controller_v2
//  Description : Self-checking bench for point_controller_v2. Expected read,
//                write and completion behaviour is derived from the loop
//                arithmetic (read j -> channel/pixel/filter, write k -> base+k)
//                indexed by the count of unstalled busy cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_point_controller_v2;

    localparam int W_ADDR_W  = 10;
    localparam int RD_ADDR_W = 13;
    localparam int WR_ADDR_W = 14;
    localparam int WIN_W     = 14;
    localparam int CH_W      = 4;
    localparam int FN_W      = 6;
    localparam int PIPE_LAT  = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 Point_Enable;
    logic [W_ADDR_W-1:0]  W_start_address;
    logic [RD_ADDR_W-1:0] rd_base_address;
    logic [WR_ADDR_W-1:0] wr_base_address;
    logic [CH_W-1:0]      filter_channel_max;
    logic [FN_W-1:0]      filter_number_max;
    logic [WIN_W-1:0]     window_size_max;
    logic                 activation_function_enable;
    logic                 stall;
    logic                 weights_read_en;
    logic [W_ADDR_W-1:0]  weights_address;
    logic                 data_read_en;
    logic [RD_ADDR_W-1:0] read_data_address;
    logic                 data_write_en;
    logic [WR_ADDR_W-1:0] write_data_address;
    logic                 act_en;
    logic                 acc_clear;
    logic                 busy;
    logic                 Point_End;

    int n_checks = 0;
    int n_fail   = 0;

    // Last addresses the model expects the DUT to have issued
    int last_w  = 0;
    int last_rd = 0;
    int last_wr = 0;

    point_controller_v2 #(
        .W_ADDR_W (W_ADDR_W),
        .RD_ADDR_W(RD_ADDR_W),
        .WR_ADDR_W(WR_ADDR_W),
        .WIN_W    (WIN_W),
        .CH_W     (CH_W),
        .FN_W     (FN_W),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .Point_Enable              (Point_Enable),
        .W_start_address           (W_start_address),
        .rd_base_address           (rd_base_address),
        .wr_base_address           (wr_base_address),
        .filter_channel_max        (filter_channel_max),
        .filter_number_max         (filter_number_max),
        .window_size_max           (window_size_max),
        .activation_function_enable(activation_function_enable),
        .stall                     (stall),
        .weights_read_en           (weights_read_en),
        .weights_address           (weights_address),
        .data_read_en              (data_read_en),
        .read_data_address         (read_data_address),
        .data_write_en             (data_write_en),
        .write_data_address        (write_data_address),
        .act_en                    (act_en),
        .acc_clear                 (acc_clear),
        .busy                      (busy),
        .Point_End                 (Point_End)
    );

    always #5 clk = ~clk;

    // One complete start-to-done run, checked every cycle against the loop model
    task automatic test_run(input string name, input int C, input int F, input int P,
                            input int wb, input int rb, input int wrb, input bit act,
                            input int stall_pct, input int ws, input int wl);
        int n, target, u, budget, j, jw, cc, pp, ff;
        bit st, ended, e_rde, e_wre, e_acc;
        logic [6:0] got_s, exp_s;
        logic [W_ADDR_W+RD_ADDR_W+WR_ADDR_W-1:0] got_a, exp_a;
        n      = C * F * P;
        target = (n == 0) ? 1 : 1 + n + PIPE_LAT;
        budget = 3 * target + wl + 40;
        u      = 0;
        ended  = 1'b0;

        @(posedge clk); #1;
        W_start_address            = W_ADDR_W'(wb);
        rd_base_address            = RD_ADDR_W'(rb);
        wr_base_address            = WR_ADDR_W'(wrb);
        filter_channel_max         = CH_W'(C);
        filter_number_max          = FN_W'(F);
        window_size_max            = WIN_W'(P);
        activation_function_enable = act;
        Point_Enable               = 1'b1;
        stall                      = 1'b0;
        @(posedge clk); #1;
        Point_Enable               = 1'b0;
        // Config after start must have no effect
        W_start_address            = W_ADDR_W'($urandom);
        rd_base_address            = RD_ADDR_W'($urandom);
        wr_base_address            = WR_ADDR_W'($urandom);
        filter_channel_max         = CH_W'($urandom);
        filter_number_max          = FN_W'($urandom);
        window_size_max            = WIN_W'($urandom);
        activation_function_enable = ~act;

        for (int k = 0; k < budget && !ended; k++) begin
            st           = (k >= ws && k < ws + wl) || (int'($urandom_range(99)) < stall_pct);
            stall        = st;
            Point_Enable = ($urandom_range(7) == 0);
            @(negedge clk);
            ended = (u == target);
            e_rde = !ended && !st && u >= 1 && u <= n;
            e_acc = 1'b0;
            if (e_rde) begin
                j       = u - 1;
                cc      = j % C;
                pp      = (j / C) % P;
                ff      = j / (C * P);
                last_rd = (rb + cc * P + pp) % (1 << RD_ADDR_W);
                last_w  = (wb + ff * C + cc) % (1 << W_ADDR_W);
                e_acc   = (cc == 0);
            end
            e_wre = 1'b0;
            jw    = u - 1 - PIPE_LAT;
            if (!ended && !st && n > 0 && jw >= 0 && jw < n) begin
                if (jw % C == C - 1) begin
                    e_wre   = 1'b1;
                    last_wr = (wrb + jw / C) % (1 << WR_ADDR_W);
                end
            end
            exp_s = {e_rde, e_rde, e_acc, e_wre, e_wre && act, !ended, ended};
            got_s = {weights_read_en, data_read_en, acc_clear, data_write_en, act_en, busy, Point_End};
            n_checks++;
            if (got_s !== exp_s) begin
                n_fail++;
                $display("FAIL %s strobes cyc %0d (wre,dre,acc,dwe,act,busy,end): got %b expected %b",
                         name, k, got_s, exp_s);
            end
            exp_a = {W_ADDR_W'(last_w), RD_ADDR_W'(last_rd), WR_ADDR_W'(last_wr)};
            got_a = {weights_address, read_data_address, write_data_address};
            n_checks++;
            if (got_a !== exp_a) begin
                n_fail++;
                $display("FAIL %s addr cyc %0d (w,rd,wr): got %0d,%0d,%0d expected %0d,%0d,%0d",
                         name, k, weights_address, read_data_address, write_data_address,
                         last_w, last_rd, last_wr);
            end
            if (!ended && !st) u++;
            @(posedge clk); #1;
        end
        stall        = 1'b0;
        Point_Enable = 1'b0;

        n_checks++;
        if (!ended) begin
            n_fail++;
            $display("FAIL %s timeout: got no Point_End in %0d cycles, expected after %0d unstalled cycles",
                     name, budget, target);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, Point_End} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s after_done busy,end: got %b expected 00", name, {busy, Point_End});
        end
    endtask

    task automatic test_reset();
        rst                        = 1'b1;
        Point_Enable               = 1'b0;
        stall                      = 1'b0;
        W_start_address            = '0;
        rd_base_address            = '0;
        wr_base_address            = '0;
        filter_channel_max         = '0;
        filter_number_max          = '0;
        window_size_max            = '0;
        activation_function_enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({weights_read_en, data_read_en, acc_clear, data_write_en, act_en, busy, Point_End} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset strobes: got %b expected 0000000",
                     {weights_read_en, data_read_en, acc_clear, data_write_en, act_en, busy, Point_End});
        end
        n_checks++;
        if ({weights_address, read_data_address, write_data_address} !== '0) begin
            n_fail++;
            $display("FAIL reset addr: got %0d,%0d,%0d expected 0,0,0",
                     weights_address, read_data_address, write_data_address);
        end
        @(posedge clk); #1;
        rst     = 1'b0;
        last_w  = 0;
        last_rd = 0;
        last_wr = 0;
    endtask

    task automatic test_basic();
        test_run("T1_basic", 2, 1, 4, 0, 0, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_large_window();
        test_run("T2_large", 1, 1, 3136, 0, 0, 0, 1'b1, 0, 0, 0);
    endtask

    task automatic test_bases();
        test_run("T3_bases", 2, 2, 2, 100, 0, 50, 1'b0, 0, 0, 0);
    endtask

    task automatic test_stall();
        test_run("T4_stall", 2, 1, 4, 0, 0, 0, 1'b0, 0, 4, 5);
    endtask

    task automatic test_zero_config();
        test_run("T5_f0", 2, 0, 4, 7, 9, 11, 1'b1, 0, 0, 0);
        test_run("T5_c0", 0, 3, 4, 7, 9, 11, 1'b1, 0, 0, 0);
        test_run("T5_p0", 2, 3, 0, 7, 9, 11, 1'b1, 0, 0, 0);
    endtask

    task automatic test_midrun_reset();
        @(posedge clk); #1;
        W_start_address            = '0;
        rd_base_address            = '0;
        wr_base_address            = '0;
        filter_channel_max         = CH_W'(2);
        filter_number_max          = FN_W'(1);
        window_size_max            = WIN_W'(4);
        activation_function_enable = 1'b0;
        Point_Enable               = 1'b1;
        @(posedge clk); #1;
        Point_Enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        last_w  = 0;
        last_rd = 0;
        last_wr = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            n_checks++;
            if ({weights_read_en, data_read_en, data_write_en, busy, Point_End,
                 weights_address, read_data_address, write_data_address} !== '0) begin
                n_fail++;
                $display("FAIL T6_after_rst cyc %0d: got rd=%b wr=%b busy=%b end=%b addr %0d,%0d,%0d expected all 0",
                         k, data_read_en, data_write_en, busy, Point_End,
                         weights_address, read_data_address, write_data_address);
            end
            @(posedge clk); #1;
        end
        test_run("T6_rerun", 2, 1, 4, 0, 0, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            test_run("RND", int'($urandom_range(4, 1)), int'($urandom_range(3, 1)),
                     int'($urandom_range(6, 1)), int'($urandom_range(1023)),
                     int'($urandom_range(8191)), int'($urandom_range(16383)),
                     1'($urandom_range(1)), 25, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_large_window();
        test_bases();
        test_stall();
        test_zero_config();
        test_midrun_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
